mem_arbiter: RTL and testbench

Two-port controller in front of the single-port word-addressed `memory` block (1024 × 32, negedge read/write, per-byte write enables). It arbitrates the core's instruction-fetch port and load/store port onto the one memory port with round-robin fairness. It converts byte addresses to word indices, builds byte selects and store-data lane shifts, and extracts and sign-extends sub-word load data. Every access is a fixed 3-cycle transaction with a req/ack handshake; illegal accesses complete with an error flag and never touch memory.

---
 rtl/mem_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter placing a fetch port and a load/store port onto one
// single-port word memory; every access is a fixed IDLE/ACCESS/DONE sequence.
module mem_arbiter #(
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic        d_unsigned,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wen,
  output logic        mem_ren,
  output logic [3:0]  mem_byte_sel,
  input  logic [31:0] mem_rdata
);
  localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) << 2;
  localparam logic [1:0]  SZ_BYTE = 2'b00;
  localparam logic [1:0]  SZ_HALF = 2'b01;
  localparam logic [1:0]  SZ_WORD = 2'b10;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  function automatic logic access_err(logic [31:0] addr, logic [1:0] size);
    logic err;
    err = ({1'b0, addr} >= ADDR_LIMIT);
    case (size)
      SZ_BYTE: err = err;
      SZ_HALF: err = err | addr[0];
      SZ_WORD: err = err | (addr[1:0] != 2'b00);
      default: err = 1'b1;
    endcase
    return err;
  endfunction

  function automatic logic [3:0] store_sel(logic [1:0] lane, logic [1:0] size);
    case (size)
      SZ_BYTE: return 4'b0001 << lane;
      SZ_HALF: return 4'b0011 << lane;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(logic [31:0] rdata, logic [1:0] lane,
                                           logic [1:0] size, logic uns);
    logic [31:0] w;
    w = rdata >> {lane, 3'b000};
    case (size)
      SZ_BYTE: return {{24{~uns & w[7]}}, w[7:0]};
      SZ_HALF: return {{16{~uns & w[15]}}, w[15:0]};
      default: return w;
    endcase
  endfunction

  state_e      state_q;
  logic        last_data_q;
  logic        gnt_data_q;
  logic        i_ack_q, i_err_q, d_ack_q, d_err_q;
  logic [31:0] i_rdata_q, d_rdata_q;
  logic [31:0] mem_addr_q, mem_wdata_q;
  logic        mem_wen_q, mem_ren_q;
  logic [3:0]  mem_byte_sel_q;

  logic [1:0]  lane_q, size_q;
  logic        we_q, uns_q, err_q;

  logic        gnt_data_d, we_d, err_d, store_d;
  logic [31:0] addr_d;
  logic [1:0]  size_d;

  // Data wins a tie only when the previous grant went to fetch.
  always_comb begin
    gnt_data_d = d_req & (~i_req | ~last_data_q);
    addr_d     = gnt_data_d ? d_addr : i_addr;
    size_d     = gnt_data_d ? d_size : SZ_WORD;
    we_d       = gnt_data_d & d_we;
    err_d      = access_err(addr_d, size_d);
    store_d    = we_d & ~err_d;
  end

  // Decoded access, captured while waiting in IDLE; data path only.
  always_ff @(posedge clk) begin
    if (state_q == IDLE) begin
      lane_q <= addr_d[1:0];
      size_q <= size_d;
      we_q   <= we_d;
      uns_q  <= d_unsigned;
      err_q  <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      last_data_q    <= 1'b1;
      gnt_data_q     <= 1'b0;
      i_ack_q        <= 1'b0;
      i_err_q        <= 1'b0;
      i_rdata_q      <= '0;
      d_ack_q        <= 1'b0;
      d_err_q        <= 1'b0;
      d_rdata_q      <= '0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      mem_wen_q      <= 1'b0;
      mem_ren_q      <= 1'b0;
      mem_byte_sel_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_req || d_req) begin
            gnt_data_q     <= gnt_data_d;
            mem_addr_q     <= {2'b00, addr_d[31:2]};
            mem_ren_q      <= ~we_d & ~err_d;
            mem_wen_q      <= store_d;
            mem_byte_sel_q <= store_d ? store_sel(addr_d[1:0], size_d) : 4'b0000;
            mem_wdata_q    <= store_d ? (d_wdata << {addr_d[1:0], 3'b000}) : '0;
            state_q        <= ACCESS;
          end
        end
        // mem_rdata was refreshed at the negedge inside this cycle.
        ACCESS: begin
          mem_addr_q     <= '0;
          mem_wdata_q    <= '0;
          mem_wen_q      <= 1'b0;
          mem_ren_q      <= 1'b0;
          mem_byte_sel_q <= '0;
          if (gnt_data_q) begin
            d_ack_q   <= 1'b1;
            d_err_q   <= err_q;
            d_rdata_q <= (err_q || we_q) ? '0 : load_ext(mem_rdata, lane_q, size_q, uns_q);
          end else begin
            i_ack_q   <= 1'b1;
            i_err_q   <= err_q;
            i_rdata_q <= err_q ? '0 : mem_rdata;
          end
          state_q <= DONE;
        end
        DONE: begin
          i_ack_q     <= 1'b0;
          i_err_q     <= 1'b0;
          i_rdata_q   <= '0;
          d_ack_q     <= 1'b0;
          d_err_q     <= 1'b0;
          d_rdata_q   <= '0;
          last_data_q <= gnt_data_q;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign i_ack        = i_ack_q;
  assign i_err        = i_err_q;
  assign i_rdata      = i_rdata_q;
  assign d_ack        = d_ack_q;
  assign d_err        = d_err_q;
  assign d_rdata      = d_rdata_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_wen      = mem_wen_q;
  assign mem_ren      = mem_ren_q;
  assign mem_byte_sel = mem_byte_sel_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a byte-level reference memory and a
// negedge word memory standing in for the real memory block.
module tb_mem_arbiter;
  localparam int MEM_WORDS = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, i_ack, i_err;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_unsigned, d_ack, d_err;
  logic [1:0]  d_size;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_wen, mem_ren;
  logic [3:0]  mem_byte_sel;
  logic [31:0] mem_rdata = '0;

  mem_arbiter #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_unsigned(d_unsigned),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen), .mem_ren(mem_ren),
    .mem_byte_sel(mem_byte_sel), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory block model: strobes sampled on the falling edge.
  logic [31:0] mem    [MEM_WORDS];
  logic [31:0] init_w [MEM_WORDS];
  bit          preloaded = 1'b0;
  always @(negedge clk) begin
    if (!preloaded) begin
      for (int k = 0; k < MEM_WORDS; k++) mem[k] <= init_w[k];
      preloaded <= 1'b1;
    end else begin
      if (mem_ren) mem_rdata <= mem[mem_addr[9:0]];
      if (mem_wen)
        for (int b = 0; b < 4; b++)
          if (mem_byte_sel[b]) mem[mem_addr[9:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  typedef struct packed {
    bit        ren, wen;
    bit [31:0] maddr;
    bit [3:0]  bsel;
    bit [31:0] wdata, rdata;
    bit        err;
  } exp_t;
  typedef struct packed { bit isd; int cyc; } log_t;

  exp_t iq[$], dq[$];
  log_t glog[$];
  bit [7:0] ref_b [4*MEM_WORDS];

  task automatic chk(input string nm, input bit [31:0] act, input bit [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic bit illegal(bit [1:0] sz, bit [31:0] a);
    if (a >= 32'(4*MEM_WORDS)) return 1'b1;
    if (sz == 2'd3) return 1'b1;
    if (sz == 2'd1 && a[0]) return 1'b1;
    if (sz == 2'd2 && a[1:0] != 2'b00) return 1'b1;
    return 1'b0;
  endfunction

  // Reference: byte-addressed little-endian memory, updated at issue time.
  function automatic exp_t model(bit isd, bit we, bit [1:0] sz, bit uns,
                                 bit [31:0] a, bit [31:0] wd);
    exp_t e;
    int n;
    bit [31:0] v;
    e = '0;
    if (!isd) begin we = 1'b0; sz = 2'd2; end
    e.err = illegal(sz, a);
    if (e.err) return e;
    n = 1 << sz;
    e.maddr = a >> 2;
    if (we) begin
      e.wen = 1'b1;
      e.wdata = wd << (8 * a[1:0]);
      for (int k = 0; k < n; k++) begin
        e.bsel[int'(a[1:0]) + k] = 1'b1;
        ref_b[int'(a) + k] = wd[8*k +: 8];
      end
    end else begin
      e.ren = 1'b1;
      v = 0;
      for (int k = 0; k < n; k++) v = v | (32'(ref_b[int'(a) + k]) << (8*k));
      if (isd && !uns && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8*n)) - 1);
      e.rdata = v;
    end
    return e;
  endfunction

  logic       prev_ren, prev_wen, prev_iack, prev_dack;
  logic [31:0] prev_maddr, prev_wdata;
  logic [3:0] prev_bsel;

  task automatic check_ack(input bit isd);
    exp_t e;
    if (isd ? (dq.size() == 0) : (iq.size() == 0)) begin
      compared++; mismatched++;
      $display("FAIL unexpected_ack: port %s acked with no pending request, required no ack",
               isd ? "D" : "I");
      return;
    end
    e = isd ? dq.pop_front() : iq.pop_front();
    chk("access_ren", 32'(prev_ren), 32'(e.ren));
    chk("access_wen", 32'(prev_wen), 32'(e.wen));
    if (!e.err) begin
      chk("access_addr", prev_maddr, e.maddr);
      chk("access_bsel", 32'(prev_bsel), 32'(e.bsel));
      chk("access_wdata", prev_wdata, e.wdata);
    end
    chk(isd ? "d_rdata" : "i_rdata", isd ? d_rdata : i_rdata, e.rdata);
    chk(isd ? "d_err" : "i_err", 32'(isd ? d_err : i_err), 32'(e.err));
    glog.push_back('{isd: isd, cyc: cyc});
  endtask

  // Monitor: compares whenever an ack is presented, one delta after the edge.
  always @(posedge clk) begin
    #1;
    chk("strobe_excl", 32'(mem_ren & mem_wen), 0);
    chk("ack_excl", 32'(i_ack & d_ack), 0);
    chk("i_ack_width", 32'(i_ack & prev_iack), 0);
    chk("d_ack_width", 32'(d_ack & prev_dack), 0);
    if (i_ack) check_ack(1'b0);
    else chk("i_quiet", i_rdata | 32'(i_err), 0);
    if (d_ack) check_ack(1'b1);
    else chk("d_quiet", d_rdata | 32'(d_err), 0);
    prev_ren = mem_ren; prev_wen = mem_wen; prev_maddr = mem_addr;
    prev_wdata = mem_wdata; prev_bsel = mem_byte_sel;
    prev_iack = i_ack; prev_dack = d_ack;
  end

  task automatic wait_ack(input bit isd);
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (isd ? d_ack : i_ack) return;
    end
    compared++; mismatched++;
    $display("FAIL ack_timeout: port %s got no ack in 12 cycles, required one", isd ? "D" : "I");
  endtask

  task automatic issue_i(input bit [31:0] a, input bit hold);
    iq.push_back(model(1'b0, 1'b0, 2'd2, 1'b0, a, 32'h0));
    i_addr = a; i_req = 1'b1;
    wait_ack(1'b0);
    if (!hold) i_req = 1'b0;
  endtask

  task automatic issue_d(input bit we, input bit [1:0] sz, input bit uns,
                         input bit [31:0] a, input bit [31:0] wd, input bit hold);
    dq.push_back(model(1'b1, we, sz, uns, a, wd));
    d_we = we; d_size = sz; d_unsigned = uns; d_addr = a; d_wdata = wd; d_req = 1'b1;
    wait_ack(1'b1);
    if (!hold) d_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, required completion");
    $fatal(1);
  end

  initial begin
    bit found;
    for (int k = 0; k < MEM_WORDS; k++) init_w[k] = $urandom;
    init_w[0] = 32'h80011234;
    init_w[4] = 32'hDEADBEEF;
    init_w[32'h40] = 32'h11223344;
    for (int k = 0; k < MEM_WORDS; k++)
      for (int b = 0; b < 4; b++) ref_b[4*k + b] = init_w[k][8*b +: 8];
    rst_n = 1'b0; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_size = 0;
    d_unsigned = 0; d_addr = 0; d_wdata = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_i_ack", 32'(i_ack), 0);
    chk("rst_d_ack", 32'(d_ack), 0);
    chk("rst_mem_ren", 32'(mem_ren), 0);
    chk("rst_mem_wen", 32'(mem_wen), 0);
    chk("rst_mem_bsel", 32'(mem_byte_sel), 0);
    chk("rst_mem_addr", mem_addr, 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Both ports saturated from reset: I first, then strict alternation.
    glog.delete();
    fork
      begin
        for (int k = 0; k < 4; k++) issue_i(32'h10 + 4*k, k < 3);
        i_req = 1'b0;
      end
      begin
        for (int k = 0; k < 4; k++) issue_d(1'b0, 2'd2, 1'b0, 4*k, 0, k < 3);
        d_req = 1'b0;
      end
    join
    chk("arb_count", glog.size(), 8);
    for (int k = 0; k < glog.size(); k++) begin
      chk("arb_order", 32'(glog[k].isd), 32'(k % 2));
      if (k >= 2) chk("arb_period", glog[k].cyc - glog[k-2].cyc, 6);
    end

    issue_i(32'h10, 1'b0);
    issue_d(1'b1, 2'd0, 1'b0, 32'h103, 32'h000000AB, 1'b0);
    issue_i(32'h100, 1'b0);
    issue_d(1'b0, 2'd1, 1'b0, 32'h2, 0, 1'b0);
    issue_d(1'b0, 2'd1, 1'b1, 32'h2, 0, 1'b0);
    issue_d(1'b0, 2'd0, 1'b0, 32'h1, 0, 1'b0);
    issue_d(1'b0, 2'd2, 1'b0, 32'h6, 0, 1'b0);
    issue_d(1'b0, 2'd0, 1'b0, 32'h1000, 0, 1'b0);
    issue_d(1'b0, 2'd3, 1'b0, 32'h0, 0, 1'b0);
    issue_d(1'b1, 2'd2, 1'b0, 32'h3FFE, 32'h12345678, 1'b0);
    issue_i(32'h2, 1'b0);

    // Reset during the ACCESS cycle of a store: dropped, memory untouched.
    d_we = 1'b1; d_size = 2'd2; d_unsigned = 1'b0; d_addr = 32'h104;
    d_wdata = 32'h55AA55AA; d_req = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 6 && !found; k++) begin
      @(posedge clk); #1;
      found = mem_wen;
    end
    chk("rst_mid_wen_seen", 32'(found), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_wen", 32'(mem_wen), 0);
    chk("rst_mid_bsel", 32'(mem_byte_sel), 0);
    chk("rst_mid_wdata", mem_wdata, 0);
    d_req = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    glog.delete();
    fork
      issue_i(32'h104, 1'b0);
      issue_d(1'b0, 2'd2, 1'b0, 32'h100, 0, 1'b0);
    join
    chk("rst_tie_count", glog.size(), 2);
    if (glog.size() > 0) chk("rst_tie_first", 32'(glog[0].isd), 0);

    for (int n = 0; n < 80; n++) begin
      bit [31:0] a;
      bit [1:0] sz;
      a = ($urandom_range(0, 15) == 0) ? 32'(4*MEM_WORDS) + $urandom_range(0, 64)
                                       : 32'($urandom_range(0, 255));
      sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      if ($urandom_range(0, 2) == 0) issue_i(a & ~32'h3 | (($urandom_range(0, 7) == 0) ? 32'h1 : 32'h0), 1'b0);
      else issue_d(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, 1'b0);
    end

    repeat (4) @(posedge clk);
    #1;
    chk("iq_drained", iq.size(), 0);
    chk("dq_drained", dq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
